// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: derives BCLK/LRCLK from CLK and serializes one stereo PCM pair per frame.
// Build option: define MUTE_ON_UNDERRUN_EN to send a silent frame on underrun instead of repeating the last pair.
module i2s_transmitter #(
  parameter int CLK_DIV      = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic signed [SAMPLE_WIDTH-1:0] SAMPLE_L,
  input  logic signed [SAMPLE_WIDTH-1:0] SAMPLE_R,
  input  logic                           SAMPLE_VALID,
  output logic                           SAMPLE_READY,
  output logic                           BCLK,
  output logic                           LRCLK,
  output logic                           SDATA,
  output logic                           FRAME_START,
  output logic                           UNDERRUN
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT   = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_WIDTH);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic                    full_q, full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;

  logic                    fall;
  logic                    right;
  logic [CNT_W-1:0]        pos;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [IDX_W-1:0]        bit_sel;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can leave it unassigned and infer a latch.
    div_d         = div_q;
    cnt_d         = cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    full_d        = full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    out_l_d       = out_l_q;
    out_r_d       = out_r_q;
    fall          = 1'b0;
    right         = 1'b0;
    pos           = '0;
    word          = '0;
    bit_sel       = '0;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (SAMPLE_VALID && !full_q) begin
      hold_l_d = SAMPLE_L;
      hold_r_d = SAMPLE_R;
      full_d   = 1'b1;
    end

    if (fall) begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      right   = (cnt_d >= SLOT_CNT);
      pos     = right ? cnt_d - SLOT_CNT : cnt_d;
      lrclk_d = right;
      word    = right ? out_r_q : out_l_q;
      // Slot position 0 is the Philips one-bit delay; the MSB follows at position 1.
      if (pos != '0 && pos <= SAMPLE_CNT) begin
        bit_sel = IDX_W'(SAMPLE_CNT - pos);
        sdata_d = word[bit_sel];
      end else begin
        sdata_d = 1'b0;
      end

      if (cnt_d == '0) begin
        frame_start_d = 1'b1;
        if (full_q) begin
          out_l_d = hold_l_q;
          out_r_d = hold_r_q;
          full_d  = 1'b0;
        end else begin
          underrun_d = 1'b1;
`ifdef MUTE_ON_UNDERRUN_EN
          out_l_d = '0;
          out_r_d = '0;
`else
          out_l_d = out_l_q;
          out_r_d = out_r_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q         <= '0;
      cnt_q         <= CNT_LAST;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b1;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      full_q        <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      out_l_q       <= '0;
      out_r_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state regardless of statement order.
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      full_q        <= full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      out_l_q       <= out_l_d;
      out_r_q       <= out_r_d;
    end
  end

  assign SAMPLE_READY = ~full_q;
  assign BCLK         = bclk_q;
  assign LRCLK        = lrclk_q;
  assign SDATA        = sdata_q;
  assign FRAME_START  = frame_start_q;
  assign UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with CLK_DIV=2 (BCLK = 4 CLKs, frame = 256 CLKs).
// Edge numbers count CLK rising edges after reset release; outputs are sampled 1 time unit after each edge.
module tb_i2s_transmitter;

  localparam int CLK_DIV = 2;
  localparam int SW      = 16;
  localparam int SLOT    = 32;

  typedef struct {
    int          edge_n;
    logic        valid;
    logic [15:0] l;
    logic [15:0] r;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        fs;
    logic        ur;
    logic        ready;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_l = 16'h0000;
  logic [15:0] sample_r = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  logic mute   = 1'b0;

  i2s_transmitter #(
    .CLK_DIV     (CLK_DIV),
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (SLOT)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .SAMPLE_L    (sample_l),
    .SAMPLE_R    (sample_r),
    .SAMPLE_VALID(sample_valid),
    .SAMPLE_READY(sample_ready),
    .BCLK        (bclk),
    .LRCLK       (lrclk),
    .SDATA       (sdata),
    .FRAME_START (frame_start),
    .UNDERRUN    (underrun)
  );

  always #5 clk = ~clk;

  // Handshakes are stable at the falling CLK edge; each one seen here is taken at the next rising edge.
  always @(negedge clk) if (!rst && sample_valid && sample_ready) acc_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Starts one edge before a frame start and leaves the bench one edge before the next frame start.
  task automatic check_frame(input logic [15:0] l, input logic [15:0] r, input logic ur,
                             input logic rdy0, input logic rdy1,
                             input logic nv, input logic [15:0] nl, input logic [15:0] nr);
    logic [15:0] w;
    logic        exp_sd;
    int          p;
    for (int n = 0; n < 64; n++) begin
      tick((n == 0) ? 1 : ((n == 1) ? 3 : 4));
      p      = n % 32;
      w      = (n < 32) ? l : r;
      exp_sd = (p >= 1 && p <= 16) ? w[16-p] : 1'b0;
      check("bclk_fall", bclk, 1'b0);
      check("lrclk", lrclk, n >= 32);
      check("sdata", sdata, exp_sd);
      if (n == 0) begin
        check("frame_start", frame_start, 1'b1);
        check("underrun", underrun, ur);
        check("ready_at_start", sample_ready, rdy0);
        tick(1);
        check("frame_start_clear", frame_start, 1'b0);
        check("underrun_clear", underrun, 1'b0);
        check("ready_after_start", sample_ready, rdy1);
        sample_valid = nv;
        sample_l     = nl;
        sample_r     = nr;
      end else begin
        check("frame_start_low", frame_start, 1'b0);
      end
    end
    tick(3);
  endtask

  vec_t        vecs[12];
  int          a0;
  logic [15:0] rep5_l, rep5_r, rep6_r;

  initial begin
`ifdef MUTE_ON_UNDERRUN_EN
    mute = 1'b1;
`endif
    rep5_l = mute ? 16'h0000 : 16'h7FFF;
    rep5_r = mute ? 16'h0000 : 16'h0123;
    rep6_r = mute ? 16'h0000 : 16'h0F0F;

    //           edge valid  L         R          bclk  lrclk sdata fs    ur    ready
    vecs[0]  = '{0,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2,   1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3,   1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{5,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{6,   1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{128, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{131, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{132, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{133, 1'b1, 16'hA5C3, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{140, 1'b0, 16'hA5C3, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // First frame after reset: timing, reset values and an underrun of silence.
    foreach (vecs[i]) begin
      sample_valid = vecs[i].valid;
      sample_l     = vecs[i].l;
      sample_r     = vecs[i].r;
      while (cyc < vecs[i].edge_n) tick(1);
      check("vec_bclk", bclk, vecs[i].bclk);
      check("vec_lrclk", lrclk, vecs[i].lrclk);
      check("vec_sdata", sdata, vecs[i].sdata);
      check("vec_frame_start", frame_start, vecs[i].fs);
      check("vec_underrun", underrun, vecs[i].ur);
      check("vec_ready", sample_ready, vecs[i].ready);
    end

    tick(259 - cyc);
    check("ready_held_low", sample_ready, 1'b0);
    check("lrclk_last_bit", lrclk, 1'b1);

    // Streaming with VALID held high: one new pair accepted per frame.
    sample_valid = 1'b1;
    sample_l     = 16'h1234;
    sample_r     = 16'hFEDC;
    a0 = acc_cnt;
    check_frame(16'hA5C3, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h0001);
    check_int("accepts_frame2", acc_cnt - a0, 1);
    a0 = acc_cnt;
    check_frame(16'h1234, 16'hFEDC, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h0123);
    check_int("accepts_frame3", acc_cnt - a0, 1);
    a0 = acc_cnt;
    check_frame(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_int("accepts_frame4", acc_cnt - a0, 1);
    a0 = acc_cnt;
    check_frame(16'h7FFF, 16'h0123, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check_int("accepts_frame5", acc_cnt - a0, 0);

    // Producer stops: underrun repeats (or mutes) the last pair.
    check_frame(rep5_l, rep5_r, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);

    // Pair captured on the frame-start edge itself: this frame underruns, the pair goes out next frame.
    sample_valid = 1'b1;
    sample_l     = 16'hBEEF;
    sample_r     = 16'h0F0F;
    a0 = acc_cnt;
    check_frame(rep5_l, rep5_r, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_int("accepts_frame7", acc_cnt - a0, 1);
    check_frame(16'hBEEF, 16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);

    // Reset in the middle of the right slot of the next (underrun) frame.
    tick(150);
    check("pre_reset_lrclk", lrclk, 1'b1);
    check("pre_reset_sdata", sdata, mute ? 1'b0 : rep6_r[11]);
    rst = 1'b1;
    #1;
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b1);
    check("rst_sdata", sdata, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", sample_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    tick(3);
    check("rel_bclk_high", bclk, 1'b1);
    check("rel_no_frame_yet", frame_start, 1'b0);
    tick(1);
    check("rel_frame_start", frame_start, 1'b1);
    check("rel_underrun", underrun, 1'b1);
    check("rel_lrclk", lrclk, 1'b0);
    check("rel_sdata", sdata, 1'b0);
    tick(127);
    check("rel_lrclk_left", lrclk, 1'b0);
    tick(1);
    check("rel_lrclk_right", lrclk, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
